fm_sweep_ctrl: RTL and testbench
================================

// Module: fm_sweep_ctrl
// PURPOSE
//  Carrier-frequency sweep/hop scheduler for the DDS-based analog modulator.
//  Steps a 32-bit phase-increment (fre_word) from a start word to a stop word in
//  fixed increments, holding each point for a programmable dwell time.
//  Replaces a static fre_word source; its fre_word output drives the
//  modulator's frequency input in the clk_500m or clk_50m domain.
// PARAMETERS
//  DWELL_W     24            width of the dwell counter / cfg_dwell
//  CNT_W       16            width of sweep_cnt
//  RESET_WORD  32'd105       fre_word value out of reset
// PORTS
//  clk_in          in   1        system clock
//  rst_n           in   1        asynchronous reset, active low
//  start           in   1        1-cycle request; sampled only in IDLE
//  abort           in   1        stop the sweep immediately
//  cfg_start_word  in   32       first frequency word
//  cfg_stop_word   in   32       last frequency word (direction = sign of stop-start)
//  cfg_step_word   in   32       step magnitude, unsigned
//  cfg_dwell       in   DWELL_W  cycles per point (0 treated as 1)
//  cfg_continuous  in   1        1 = repeat the sweep until abort
//  fre_word        out  32       frequency word to the modulator
//  word_valid      out  1        1-cycle pulse whenever fre_word takes a new point
//  busy            out  1        high while a sweep is active
//  done            out  1        1-cycle pulse when a single sweep completes
//  sweep_cnt       out  CNT_W    completed sweeps since start, wraps
// BEHAVIOUR
//  - Reset: fre_word=RESET_WORD; word_valid=busy=done=0; sweep_cnt=0; state IDLE.
//  - States: IDLE -> DWELL -> (DWELL | DONE | IDLE); DONE -> IDLE.
//  - cfg_* is latched on accepted start; later cfg changes do not affect the running sweep.
//  - Latency: start high in cycle N -> cycle N+1: fre_word=cfg_start_word, word_valid=1,
//    busy=1, sweep_cnt=0.
//  - Each point is held exactly max(cfg_dwell,1) cycles. The next point (with word_valid)
//    is issued in the cycle after the last dwell cycle.
//  - Up sweep (stop>=start): next=cur+step. Down sweep: next=cur-step. Use 33-bit math.
//    If next passes stop, or overflows/underflows 32 bits, next=stop (clamp).
//    The stop point is always emitted exactly once per pass.
//  - step==0 or start==stop: single point; hold it for the dwell time, then end.
//  - End of pass, cfg_continuous=0: in the cycle after the stop point's last dwell cycle,
//    done=1 and busy=0 (DONE state, 1 cycle), then IDLE. fre_word holds the stop word.
//  - End of pass, cfg_continuous=1: sweep_cnt++ and the next pass begins at start
//    (word_valid=1). No dwell gap and no done pulse.
//  - abort is effective in any state, next cycle: IDLE, busy=0, no done pulse,
//    fre_word holds its current value.
//  - abort and start in the same IDLE cycle: abort wins, start is ignored.
//  - start while busy: ignored.
//  - rst_n asserted mid-sweep: outputs return to reset values asynchronously.
// CONFIGURATION
//  FM_SWEEP_TRIANGLE_EN defined: in continuous mode, passes alternate direction
//    (start->stop, stop->start, ...). The turnaround endpoint is not repeated.
//    sweep_cnt increments at each endpoint.
//  Not defined: continuous mode is sawtooth only (restarts at start). Ports are identical.
// TESTING
//  1. start=1000, stop=1030, step=10, dwell=4, start at cycle 0 -> fre_word takes
//     1000/1010/1020/1030, each for 4 cycles from cycle 1. word_valid at cycles 1,5,9,13;
//     done at 17; busy 1..16.
//  2. start=0, stop=25, step=10, dwell=1 -> 0,10,20,25 then done. Clamp; 25 emitted once.
//  3. start=100, stop=80, step=10, dwell=2 -> 100,90,80 (down sweep), done pulse.
//  4. start=32'hFFFF_FFF0, stop=32'hFFFF_FFFF, step=32'h20 -> FFFF_FFF0 then FFFF_FFFF
//     (overflow clamp); no wrap to a small value.
//  5. continuous, start=0, stop=20, step=10, dwell=3, abort at cycle 20 -> sawtooth
//     0,10,20,0,10,...; sweep_cnt=2 at abort; busy=0 at 21; done never pulses;
//     fre_word frozen.
//  6. Edge cases: start+abort in the same cycle, and start while busy -> both ignored.
//     Reset mid-sweep -> fre_word=105 at once. With FM_SWEEP_TRIANGLE_EN, test 5 gives
//     0,10,20,10,0,10.

Source files
------------

// File: rtl/fm_sweep_ctrl.sv
// rtl/fm_sweep_ctrl.sv - DDS frequency-word sweep/hop scheduler; FM_SWEEP_TRIANGLE_EN selects triangle continuous mode
module fm_sweep_ctrl #(
    parameter int          DWELL_W    = 24,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] RESET_WORD = 32'd105
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        cfg_start_word,
    input  logic [31:0]        cfg_stop_word,
    input  logic [31:0]        cfg_step_word,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    output logic [31:0]        fre_word,
    output logic               word_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sweep_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        start_q, start_d;
    logic [31:0]        stop_q, stop_d;
    logic [31:0]        step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic               base_up_q, base_up_d;
    logic               rev_q, rev_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [31:0]        word_q, word_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        pass_tgt;
    logic               pass_up;
    logic               last_dwell;
    logic               pass_end;

    // One step toward tgt in 33-bit arithmetic; overshoot or wrap clamps to tgt.
    function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] stp,
                                                input logic        up);
        logic [32:0] s;
        if (up) begin
            s = {1'b0, cur} + {1'b0, stp};
            step_toward = (s[32] || (s[31:0] > tgt)) ? tgt : s[31:0];
        end else begin
            s = {1'b0, cur} - {1'b0, stp};
            step_toward = (s[32] || (s[31:0] < tgt)) ? tgt : s[31:0];
        end
    endfunction

    // A reverse pass (triangle only) heads back to the start word.
    assign pass_tgt   = rev_q ? start_q : stop_q;
    assign pass_up    = rev_q ? ~base_up_q : base_up_q;
    assign last_dwell = (dwell_cnt_q == (dwell_q - 1'b1));
    assign pass_end   = (word_q == pass_tgt) || (step_q == '0);

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        base_up_d   = base_up_q;
        rev_d       = rev_q;
        dwell_cnt_d = dwell_cnt_q;
        word_d      = word_q;
        valid_d     = 1'b0;
        cnt_d       = cnt_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        start_d     = cfg_start_word;
                        stop_d      = cfg_stop_word;
                        step_d      = cfg_step_word;
                        dwell_d     = (cfg_dwell == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : cfg_dwell;
                        cont_d      = cfg_continuous;
                        base_up_d   = (cfg_stop_word >= cfg_start_word);
                        rev_d       = 1'b0;
                        dwell_cnt_d = '0;
                        word_d      = cfg_start_word;
                        valid_d     = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (!last_dwell) begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end else begin
                        dwell_cnt_d = '0;
                        if (!pass_end) begin
                            word_d  = step_toward(word_q, pass_tgt, step_q, pass_up);
                            valid_d = 1'b1;
                        end else if (!cont_q) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            valid_d = 1'b1;
`ifdef FM_SWEEP_TRIANGLE_EN
                            // Turn around from the endpoint just held, without repeating it.
                            rev_d  = ~rev_q;
                            word_d = step_toward(word_q, rev_q ? stop_q : start_q, step_q,
                                                 rev_q ? base_up_q : ~base_up_q);
`else
                            word_d = start_q;
`endif
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
            base_up_q   <= 1'b1;
            rev_q       <= 1'b0;
            dwell_cnt_q <= '0;
            word_q      <= RESET_WORD;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            cont_q      <= cont_d;
            base_up_q   <= base_up_d;
            rev_q       <= rev_d;
            dwell_cnt_q <= dwell_cnt_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fre_word   = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q == S_DWELL);
    assign done       = (state_q == S_DONE);
    assign sweep_cnt  = cnt_q;

endmodule

// File: tb/tb_fm_sweep_ctrl.sv
// tb/tb_fm_sweep_ctrl.sv - directed vector bench for fm_sweep_ctrl
module tb_fm_sweep_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg_start_word;
    logic [31:0] cfg_stop_word;
    logic [31:0] cfg_step_word;
    logic [23:0] cfg_dwell;
    logic        cfg_continuous;
    logic [31:0] fre_word;
    logic        word_valid;
    logic        busy;
    logic        done;
    logic [15:0] sweep_cnt;

    always #5 clk_in = ~clk_in;

    fm_sweep_ctrl dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_start_word (cfg_start_word),
        .cfg_stop_word  (cfg_stop_word),
        .cfg_step_word  (cfg_step_word),
        .cfg_dwell      (cfg_dwell),
        .cfg_continuous (cfg_continuous),
        .fre_word       (fre_word),
        .word_valid     (word_valid),
        .busy           (busy),
        .done           (done),
        .sweep_cnt      (sweep_cnt)
    );

    typedef struct {
        logic [31:0]       sw;
        logic [31:0]       pw;
        logic [31:0]       st;
        logic [23:0]       dwell;
        int                np;
        logic [0:5][31:0]  pts;
    } vec_t;

    vec_t vecs[7];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k);
        int d;
        d = (vecs[k].dwell == 24'd0) ? 1 : int'(vecs[k].dwell);
        cfg_start_word = vecs[k].sw;
        cfg_stop_word  = vecs[k].pw;
        cfg_step_word  = vecs[k].st;
        cfg_dwell      = vecs[k].dwell;
        cfg_continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        // scramble cfg to show the running sweep uses the latched copy
        cfg_start_word = $urandom;
        cfg_stop_word  = $urandom;
        cfg_step_word  = $urandom;
        cfg_dwell      = 24'd0;
        cfg_continuous = 1'b1;
        for (int p = 0; p < vecs[k].np; p++) begin
            for (int j = 0; j < d; j++) begin
                chk($sformatf("v%0d p%0d c%0d fre_word", k, p, j), fre_word, vecs[k].pts[p]);
                chk($sformatf("v%0d p%0d c%0d word_valid", k, p, j), 32'(word_valid), (j == 0) ? 32'd1 : 32'd0);
                chk($sformatf("v%0d p%0d c%0d busy", k, p, j), 32'(busy), 32'd1);
                chk($sformatf("v%0d p%0d c%0d done", k, p, j), 32'(done), 32'd0);
                if (p == 0 && j == 0) chk($sformatf("v%0d sweep_cnt", k), 32'(sweep_cnt), 32'd0);
                tick();
            end
        end
        chk($sformatf("v%0d end done", k), 32'(done), 32'd1);
        chk($sformatf("v%0d end busy", k), 32'(busy), 32'd0);
        chk($sformatf("v%0d end word_valid", k), 32'(word_valid), 32'd0);
        chk($sformatf("v%0d end fre_word", k), fre_word, vecs[k].pts[vecs[k].np-1]);
        tick();
        chk($sformatf("v%0d idle done", k), 32'(done), 32'd0);
        chk($sformatf("v%0d idle busy", k), 32'(busy), 32'd0);
        chk($sformatf("v%0d idle fre_word", k), fre_word, vecs[k].pts[vecs[k].np-1]);
    endtask

    logic [0:6][31:0] cont_pts;
    logic [0:6][15:0] cont_cnt;

    initial begin
        vecs[0] = '{32'd1000, 32'd1030, 32'd10, 24'd4, 4,
                    {32'd1000, 32'd1010, 32'd1020, 32'd1030, 32'd0, 32'd0}};
        vecs[1] = '{32'd0, 32'd25, 32'd10, 24'd1, 4,
                    {32'd0, 32'd10, 32'd20, 32'd25, 32'd0, 32'd0}};
        vecs[2] = '{32'd100, 32'd80, 32'd10, 24'd2, 3,
                    {32'd100, 32'd90, 32'd80, 32'd0, 32'd0, 32'd0}};
        vecs[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd2, 2,
                    {32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0}};
        vecs[4] = '{32'd500, 32'd500, 32'd7, 24'd3, 1,
                    {32'd500, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
        vecs[5] = '{32'd300, 32'd900, 32'd0, 24'd2, 1,
                    {32'd300, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
        vecs[6] = '{32'd50, 32'd0, 32'd20, 24'd0, 4,
                    {32'd50, 32'd30, 32'd10, 32'd0, 32'd0, 32'd0}};
`ifdef FM_SWEEP_TRIANGLE_EN
        cont_pts = {32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20};
        cont_cnt = {16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2};
`else
        cont_pts = {32'd0, 32'd10, 32'd20, 32'd0, 32'd10, 32'd20, 32'd0};
        cont_cnt = {16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
`endif

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_start_word = '0;
        cfg_stop_word  = '0;
        cfg_step_word  = '0;
        cfg_dwell      = '0;
        cfg_continuous = 1'b0;
        tick();
        tick();
        chk("reset fre_word", fre_word, 32'd105);
        chk("reset word_valid", 32'(word_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sweep_cnt", 32'(sweep_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post-reset fre_word", fre_word, 32'd105);

        for (int k = 0; k < 7; k++) run_vec(k);

        // continuous mode, abort while a pass is running
        cfg_start_word = 32'd0;
        cfg_stop_word  = 32'd20;
        cfg_step_word  = 32'd10;
        cfg_dwell      = 24'd3;
        cfg_continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("cont c%0d fre_word", c), fre_word, cont_pts[(c-1)/3]);
            chk($sformatf("cont c%0d sweep_cnt", c), 32'(sweep_cnt), 32'(cont_cnt[(c-1)/3]));
            chk($sformatf("cont c%0d word_valid", c), 32'(word_valid), ((c-1)%3 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont c%0d busy", c), 32'(busy), 32'd1);
            chk($sformatf("cont c%0d done", c), 32'(done), 32'd0);
            if (c == 20) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        for (int c = 21; c <= 23; c++) begin
            chk($sformatf("abort c%0d busy", c), 32'(busy), 32'd0);
            chk($sformatf("abort c%0d done", c), 32'(done), 32'd0);
            chk($sformatf("abort c%0d word_valid", c), 32'(word_valid), 32'd0);
            chk($sformatf("abort c%0d fre_word", c), fre_word, cont_pts[6]);
            chk($sformatf("abort c%0d sweep_cnt", c), 32'(sweep_cnt), 32'(cont_cnt[6]));
            tick();
        end

        // start and abort together in IDLE: start loses
        cfg_start_word = 32'd777;
        cfg_continuous = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", 32'(busy), 32'd0);
        chk("start+abort word_valid", 32'(word_valid), 32'd0);
        chk("start+abort fre_word", fre_word, cont_pts[6]);
        tick();
        chk("start+abort later busy", 32'(busy), 32'd0);

        // start while busy is ignored, then reset mid-sweep
        cfg_start_word = 32'd1000;
        cfg_stop_word  = 32'd1030;
        cfg_step_word  = 32'd10;
        cfg_dwell      = 24'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy-start c1 fre_word", fre_word, 32'd1000);
        cfg_start_word = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy-start c2 fre_word", fre_word, 32'd1000);
        tick();
        chk("busy-start c3 fre_word", fre_word, 32'd1000);
        chk("busy-start c3 word_valid", 32'(word_valid), 32'd0);
        tick();
        tick();
        chk("busy-start c5 fre_word", fre_word, 32'd1010);
        chk("busy-start c5 word_valid", 32'(word_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset fre_word", fre_word, 32'd105);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset word_valid", 32'(word_valid), 32'd0);
        chk("async reset sweep_cnt", 32'(sweep_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("after reset busy", 32'(busy), 32'd0);
        run_vec(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
